// File: rtl/alu_result_stage.sv
// Single-entry result register between the ALU and register-file writeback.
// Also owns the architectural C/Z/V flags and their interrupt shadow copy.
module alu_result_stage #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned REG_AW      = 3,
   parameter int unsigned ZERO_REG_RO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_co,
   input  logic              alu_ov,
   input  logic [REG_AW-1:0] dest,
   input  logic              wr_req,
   input  logic              flag_upd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [REG_AW-1:0] rf_waddr,
   output logic              rf_we,
   output logic              c_flag,
   output logic              z_flag,
   output logic              v_flag,
   input  logic              int_save,
   input  logic              int_restore,
   output logic              sc_flag,
   output logic              sz_flag,
   output logic              sv_flag
);

   logic              valid_q, valid_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [REG_AW-1:0] addr_q, addr_d;

   logic c_q, c_d, z_q, z_d, v_q, v_d;
   logic sc_q, sc_d, sz_q, sz_d, sv_q, sv_d;

   logic accept;
   logic consume;
   logic addr_is_zero;

   always_comb begin
      in_ready = !valid_q || out_ready;
      accept   = in_valid && in_ready;
      consume  = valid_q && out_ready;
   end

   // Entry register: accept in the same cycle as consume replaces the entry.
   always_comb begin
      valid_d = valid_q;
      wr_d    = wr_q;
      data_d  = data_q;
      addr_d  = addr_q;
      if (consume) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         valid_d = 1'b1;
         wr_d    = wr_req;
         data_d  = alu_out;
         addr_d  = dest;
      end
   end

   // Restore beats a same-cycle flag update; save sees the post-update value
   // and is ignored when restore is also asserted.
   always_comb begin
      c_d  = c_q;
      z_d  = z_q;
      v_d  = v_q;
      sc_d = sc_q;
      sz_d = sz_q;
      sv_d = sv_q;
      if (accept && flag_upd) begin
         c_d = alu_co;
         z_d = (alu_out == '0);
         v_d = alu_ov;
      end
      if (int_restore) begin
         c_d = sc_q;
         z_d = sz_q;
         v_d = sv_q;
      end else if (int_save) begin
         sc_d = c_d;
         sz_d = z_d;
         sv_d = v_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         v_q     <= 1'b0;
         sc_q    <= 1'b0;
         sz_q    <= 1'b0;
         sv_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         c_q     <= c_d;
         z_q     <= z_d;
         v_q     <= v_d;
         sc_q    <= sc_d;
         sz_q    <= sz_d;
         sv_q    <= sv_d;
      end
   end

   always_comb begin
      addr_is_zero = (addr_q == '0);
      out_valid    = valid_q;
      rf_wdata     = data_q;
      rf_waddr     = addr_q;
      rf_we        = valid_q && wr_q && !((ZERO_REG_RO != 0) && addr_is_zero);
      c_flag       = c_q;
      z_flag       = z_q;
      v_flag       = v_q;
      sc_flag      = sc_q;
      sz_flag      = sz_q;
      sv_flag      = sv_q;
   end

endmodule
